// File: rtl/display_pkg.sv
// Shared constants for the 4-digit BCD display and its clients: state encoding
// for the display-sharing arbiter and the digit packing width.
package display_pkg;

  localparam int unsigned DIGITS  = 4;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned WORD_W  = DIGITS * DIGIT_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_OWN0 = ST_OWN0,
    S_OWN1 = ST_OWN1
  } arb_state_t;

endpackage

// File: rtl/display_share_arb_if.sv
// Requester/display bundle for the display-sharing arbiter: two request/data
// pairs in, grants and the four registered BCD digits out.
interface display_share_arb_if;
  import display_pkg::*;

  logic              req0;
  logic [WORD_W-1:0] data0;
  logic              req1;
  logic [WORD_W-1:0] data1;
  logic              gnt0;
  logic              gnt1;
  logic [DIGIT_W-1:0] bcd0;
  logic [DIGIT_W-1:0] bcd1;
  logic [DIGIT_W-1:0] bcd2;
  logic [DIGIT_W-1:0] bcd3;
  logic              busy;

  // Requester side (CPU MMIO + debug source, or a testbench).
  modport master (
    output req0, data0, req1, data1,
    input  gnt0, gnt1, bcd0, bcd1, bcd2, bcd3, busy
  );

  // Arbiter side.
  modport slave (
    input  req0, data0, req1, data1,
    output gnt0, gnt1, bcd0, bcd1, bcd2, bcd3, busy
  );

endinterface

// File: rtl/display_share_arb.sv
// Round-robin arbiter sharing the 7-segment display between two requesters,
// with a minimum dwell per owner and registered digits for the display mux.
module display_share_arb
  import display_pkg::*;
#(
  parameter int unsigned        DWELL_CYCLES = 100_000_000,
  parameter logic [WORD_W-1:0]  IDLE_VAL     = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  display_share_arb_if.slave bus
);

  localparam int unsigned     CNT_W   = $clog2(DWELL_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL_CYCLES - 1);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              last_q;        // 1 = requester 1 owned most recently
  logic [WORD_W-1:0] digits_q;

  logic dwell_done;
  assign dwell_done = (cnt_q == CNT_MAX);

  // NOTE: every output of a combinational block gets a default first; any
  // path that leaves it unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req0 && bus.req1) state_d = last_q ? S_OWN0 : S_OWN1;
        else if (bus.req0)        state_d = S_OWN0;
        else if (bus.req1)        state_d = S_OWN1;
      end
      S_OWN0: begin
        if (!bus.req0)                    state_d = bus.req1 ? S_OWN1 : S_IDLE;
        else if (bus.req1 && dwell_done)  state_d = S_OWN1;
      end
      S_OWN1: begin
        if (!bus.req1)                    state_d = bus.req0 ? S_OWN0 : S_IDLE;
        else if (bus.req0 && dwell_done)  state_d = S_OWN0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      digits_q <= IDLE_VAL;
    end else begin
      state_q <= state_d;

      if (state_d != state_q)
        cnt_q <= '0;
      else if (state_q != S_IDLE && !dwell_done)
        cnt_q <= cnt_q + 1'b1;

      if (state_d == S_OWN0 && state_q != S_OWN0) last_q <= 1'b0;
      if (state_d == S_OWN1 && state_q != S_OWN1) last_q <= 1'b1;

      // Loading from the next-state owner makes new digits land with the grant;
      // in IDLE the last digits are simply held.
      if (state_d == S_OWN0)      digits_q <= bus.data0;
      else if (state_d == S_OWN1) digits_q <= bus.data1;
    end
  end

  assign bus.gnt0 = (state_q == S_OWN0);
  assign bus.gnt1 = (state_q == S_OWN1);
  assign bus.busy = bus.gnt0 | bus.gnt1;

  assign bus.bcd0 = digits_q[0*DIGIT_W +: DIGIT_W];
  assign bus.bcd1 = digits_q[1*DIGIT_W +: DIGIT_W];
  assign bus.bcd2 = digits_q[2*DIGIT_W +: DIGIT_W];
  assign bus.bcd3 = digits_q[3*DIGIT_W +: DIGIT_W];

endmodule

// File: tb/tb_display_share_arb.sv
// Directed bench for display_share_arb with DWELL_CYCLES = 4: reset, single
// owner, tie-break and alternation, early release, late contender, mid reset.
module tb_display_share_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fails  = 0;

  display_share_arb_if bus ();

  display_share_arb #(
    .DWELL_CYCLES (4),
    .IDLE_VAL     (16'h0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // {busy, gnt1, gnt0, bcd3, bcd2, bcd1, bcd0}
  function automatic logic [18:0] observe();
    return {bus.busy, bus.gnt1, bus.gnt0, bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0};
  endfunction

  // Advance n edges and land 1 ns after the last one, away from the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [18:0] exp;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.data0 = 16'h0000; bus.data1 = 16'h0000;
    do_reset();
    exp = {3'b000, 16'h0000};
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (observe() !== exp) begin
        n_fails++;
        $display("FAIL reset_idle[%0d]: got %h expected %h", i, observe(), exp);
      end
      cyc(1);
    end
  endtask

  task automatic test_single_live_update();
    logic [18:0] exp;
    bus.req0 = 1'b1; bus.data0 = 16'h1234;
    cyc(1);
    exp = {3'b101, 16'h1234};
    n_checks++;
    if (observe() !== exp) begin
      n_fails++; $display("FAIL single_grant: got %h expected %h", observe(), exp);
    end
    bus.data0 = 16'h5678;
    cyc(1);
    exp = {3'b101, 16'h5678};
    n_checks++;
    if (observe() !== exp) begin
      n_fails++; $display("FAIL live_update: got %h expected %h", observe(), exp);
    end
    bus.req0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      exp = {3'b000, 16'h5678};
      n_checks++;
      if (observe() !== exp) begin
        n_fails++; $display("FAIL release_hold[%0d]: got %h expected %h", i, observe(), exp);
      end
    end
  endtask

  // Ends in OWN1 with dwell count 1 and req0/req1 both held.
  task automatic test_tie_alternate();
    logic [18:0] exp;
    do_reset();
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    bus.data0 = 16'hAAAA; bus.data1 = 16'hBBBB;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 4; k++) begin
        cyc(1);
        exp = (p % 2 == 0) ? {3'b101, 16'hAAAA} : {3'b110, 16'hBBBB};
        n_checks++;
        if (observe() !== exp) begin
          n_fails++;
          $display("FAIL alternate[p%0d c%0d]: got %h expected %h", p, k, observe(), exp);
        end
      end
    end
    cyc(2);
    exp = {3'b110, 16'hBBBB};
    n_checks++;
    if (observe() !== exp) begin
      n_fails++; $display("FAIL alternate_own1: got %h expected %h", observe(), exp);
    end
  endtask

  task automatic test_early_release();
    logic [18:0] exp;
    bus.req1 = 1'b0; bus.data0 = 16'h1357;
    cyc(1);
    exp = {3'b101, 16'h1357};
    n_checks++;
    if (observe() !== exp) begin
      n_fails++; $display("FAIL early_release: got %h expected %h", observe(), exp);
    end
    // Counter restarted at 0: the new owner must hold a full dwell of 4 cycles.
    bus.req1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      n_checks++;
      if (observe() !== exp) begin
        n_fails++; $display("FAIL early_dwell[%0d]: got %h expected %h", k, observe(), exp);
      end
    end
    cyc(1);
    exp = {3'b110, 16'hBBBB};
    n_checks++;
    if (observe() !== exp) begin
      n_fails++; $display("FAIL early_dwell_end: got %h expected %h", observe(), exp);
    end
  endtask

  task automatic test_late_contender();
    logic [18:0] exp;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    do_reset();
    bus.req1 = 1'b1; bus.data1 = 16'h2468;
    cyc(20);
    exp = {3'b110, 16'h2468};
    n_checks++;
    if (observe() !== exp) begin
      n_fails++; $display("FAIL late_owner: got %h expected %h", observe(), exp);
    end
    bus.req0 = 1'b1; bus.data0 = 16'h9753;
    cyc(1);
    exp = {3'b101, 16'h9753};
    n_checks++;
    if (observe() !== exp) begin
      n_fails++; $display("FAIL late_contender: got %h expected %h", observe(), exp);
    end
  endtask

  task automatic test_mid_reset();
    logic [18:0] exp;
    bus.req0 = 1'b0; bus.req1 = 1'b1; bus.data1 = 16'hBBBB;
    cyc(1);
    exp = {3'b110, 16'hBBBB};
    n_checks++;
    if (observe() !== exp) begin
      n_fails++; $display("FAIL mid_setup: got %h expected %h", observe(), exp);
    end
    bus.req0 = 1'b1; bus.data0 = 16'hAAAA;
    rst = 1'b1;
    cyc(1);
    exp = {3'b000, 16'h0000};
    n_checks++;
    if (observe() !== exp) begin
      n_fails++; $display("FAIL mid_reset: got %h expected %h", observe(), exp);
    end
    rst = 1'b0;
    cyc(1);
    exp = {3'b101, 16'hAAAA};
    n_checks++;
    if (observe() !== exp) begin
      n_fails++; $display("FAIL post_reset_tie: got %h expected %h", observe(), exp);
    end
  endtask

  initial begin
    test_reset();
    test_single_live_update();
    test_tie_alternate();
    test_early_release();
    test_late_contender();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/display_share_arb.md
Name: display_share_arb

Overview:
- Two-requester arbiter that shares the single 4-digit BCD 7-segment display multiplexer.
- Typical requesters: the CPU MMIO display register and a debug/status source.
- Grants ownership round-robin, with a minimum dwell time so each owner stays readable.
- Registers the owner's four BCD digits straight onto the bcd0..bcd3 inputs of the display multiplexer.

Parameters:
- DWELL_CYCLES, 100_000_000: minimum clk cycles an owner keeps the display while the other side waits (1 s at 100 MHz); must be >= 1. Bench uses 4.
- IDLE_VAL, 16'h0000: digit value {bcd3,bcd2,bcd1,bcd0} loaded at reset.

Ports:
- clk    in   1   system clock; single clock domain.
- rst    in   1   synchronous, active-high reset.
- req0   in   1   requester 0 wants the display (level; held while it wants ownership).
- data0  in   16  requester 0 digits: [3:0] = digit 0 (rightmost) ... [15:12] = digit 3.
- req1   in   1   requester 1 wants the display.
- data1  in   16  requester 1 digits, same packing.
- gnt0   out  1   requester 0 owns the display (registered).
- gnt1   out  1   requester 1 owns the display (registered).
- bcd0   out  4   digit 0 to the display mux (registered).
- bcd1   out  4   digit 1 (registered).
- bcd2   out  4   digit 2 (registered).
- bcd3   out  4   digit 3 (registered).
- busy   out  1   gnt0 | gnt1.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high on rst, and is the only reset.
- Reset values: state IDLE; gnt0 = gnt1 = 0; busy = 0; {bcd3..bcd0} = IDLE_VAL; dwell counter = 0; last_owner = 1, so requester 0 wins the first tie.
- Reset mid-operation: returns to reset values on the next edge regardless of state.
- States: IDLE, OWN0, OWN1. gnt0 = (state == OWN0); gnt1 = (state == OWN1). gnt0 and gnt1 are never both 1.
- IDLE transitions:
  - only reqX -> OWNX;
  - both requesting -> the one != last_owner;
  - none -> stay.
  - Grant appears on the edge after req is sampled (1-cycle latency).
- OWNx transitions, evaluated each edge:
  - reqx = 0 and other req = 1 -> OWN(other) (early release, no dwell wait);
  - reqx = 0 and other req = 0 -> IDLE;
  - reqx = 1, other req = 1, dwell counter == DWELL_CYCLES-1 -> OWN(other);
  - otherwise stay.
- last_owner updates to x on every entry into OWNx.
- Dwell counter:
  - width $clog2(DWELL_CYCLES+1);
  - cleared to 0 on every state change;
  - otherwise increments while in OWNx, saturating at DWELL_CYCLES-1;
  - no increment in IDLE.
- Uncontested owner: keeps the display indefinitely; counter sits saturated. A late request from the other side therefore switches on the next edge.
- DWELL_CYCLES = 1: with both requesting, ownership alternates every cycle.
- Digit register:
  - on each edge whose next state is OWNx, {bcd3..bcd0} <= datax;
  - the new owner's digits appear on the same edge as its grant;
  - live updates of datax while owning appear 1 cycle later;
  - next state IDLE: digits hold their last value, with no blanking and no flicker.
- Requesters must not assume ownership until their gnt is sampled 1. data is ignored while not granted.

Decomposition:
- Shared package display_pkg: state encoding constants (ST_IDLE = 2'd0, ST_OWN0 = 2'd1, ST_OWN1 = 2'd2) and the digit-packing constant DIGITS = 4, shared with other display clients.
- Single module, no sub-module. The dwell counter is inline. The arbiter instantiates nothing; the top level wires bcd0..bcd3 to the display mux.

Test Plan (DWELL_CYCLES = 4, IDLE_VAL = 16'h0000):
1. Reset then idle: rst = 1 for 2 cycles, no req -> gnt0 = gnt1 = 0, busy = 0, bcd3..bcd0 = 0,0,0,0; held for 10 cycles.
2. Single requester with live update:
   - req0 = 1, data0 = 16'h1234 -> next edge gnt0 = 1, bcd3..bcd0 = 1,2,3,4;
   - change data0 to 16'h5678 -> bcd = 5,6,7,8 one cycle later;
   - drop req0 -> IDLE, bcd holds 5,6,7,8.
3. Simultaneous first request:
   - after reset, req0 = req1 = 1, data0 = 16'hAAAA, data1 = 16'hBBBB -> OWN0 first, bcd = A,A,A,A;
   - after exactly 4 cycles of gnt0, switch to gnt1 with bcd = B,B,B,B;
   - alternates every 4 cycles while both are held.
4. Early release: in OWN1 with req0 = 1, drop req1 at dwell count 1 -> next edge gnt0 = 1, bcd = data0, counter 0.
5. Late contender: req1 alone for 20 cycles, then assert req0 -> gnt0 on the next edge (counter saturated).
6. Reset mid-operation: assert rst while in OWN1 with bcd = B,B,B,B -> next edge gnt1 = 0, bcd = 0,0,0,0; with both requesting after release, requester 0 wins.
